multi_cycle_ctrl: RTL and testbench

- Multi-cycle control FSM that sequences the CPU datapath (PC, instruction register, register file, ALU, synchronous-read data memory) through IF/ID/EX/MEM/WB.
- Decodes OP/func from the instruction register and issues every datapath select and write enable, one phase per clock.
- Counts retired instructions.
- Sits between the instruction register and the datapath muxes in the CPU top level.

---
 rtl/ctrl_pkg.sv | 76 +++++++
 rtl/ctrl_decode.sv | 64 ++++++
 rtl/multi_cycle_ctrl.sv | 168 ++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU control path.
//   - state_e : FSM phase encoding (also driven on the debug state port)
//   - class_e : instruction class latched in ID
//   - dec_t   : everything the decoder produces for one instruction
//   - opcode / func / ALU_OP / pc_src constants
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd7
  } state_e;

  // CL_NOP doubles as the "undecodable instruction" class.
  typedef enum logic [2:0] {
    CL_NOP  = 3'd0,
    CL_R    = 3'd1,
    CL_ALUI = 3'd2,
    CL_LW   = 3'd3,
    CL_SW   = 3'd4,
    CL_BR   = 3'd5,
    CL_J    = 3'd6
  } class_e;

  // Opcodes (Inst_code[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes (Inst_code[5:0])
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLTU = 6'b101011;
  localparam logic [5:0] FN_SLLV = 6'b000100;

  // ALU operation codes
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_XOR  = 3'b010;
  localparam logic [2:0] ALU_NOR  = 3'b011;
  localparam logic [2:0] ALU_ADD  = 3'b100;
  localparam logic [2:0] ALU_SUB  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;
  localparam logic [2:0] ALU_SLLV = 3'b111;

  // Next-PC source
  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  typedef struct packed {
    class_e     cls;
    logic [2:0] alu_op;
    logic       imm_s;
    logic       rt_imm_s;
    logic       rd_rt_s;
    logic       alu_mem_s;
    logic       br_ne;      // 1 = bne (taken on ZF=0), 0 = beq
  } dec_t;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational instruction decoder.
// Ports:
//   op_i   [5:0] in  opcode field
//   func_i [5:0] in  function field (used only for R-type)
//   dec_o  dec_t out class, ALU_OP and datapath selects
// Any encoding not listed decodes to CL_NOP with all selects 0.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] func_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o     = '0;
    dec_o.cls = CL_NOP;
    case (op_i)
      OP_RTYPE: begin
        dec_o.cls = CL_R;
        case (func_i)
          FN_ADD:  dec_o.alu_op = ALU_ADD;
          FN_SUB:  dec_o.alu_op = ALU_SUB;
          FN_AND:  dec_o.alu_op = ALU_AND;
          FN_OR:   dec_o.alu_op = ALU_OR;
          FN_XOR:  dec_o.alu_op = ALU_XOR;
          FN_NOR:  dec_o.alu_op = ALU_NOR;
          FN_SLTU: dec_o.alu_op = ALU_SLTU;
          FN_SLLV: dec_o.alu_op = ALU_SLLV;
          default: dec_o.cls    = CL_NOP;
        endcase
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTIU: begin
        dec_o.cls      = CL_ALUI;
        dec_o.rd_rt_s  = 1'b1;
        dec_o.rt_imm_s = 1'b1;
        case (op_i)
          OP_ADDI:  begin dec_o.alu_op = ALU_ADD;  dec_o.imm_s = 1'b1; end
          OP_ANDI:  dec_o.alu_op = ALU_AND;
          OP_ORI:   dec_o.alu_op = ALU_OR;
          OP_XORI:  dec_o.alu_op = ALU_XOR;
          default:  begin dec_o.alu_op = ALU_SLTU; dec_o.imm_s = 1'b1; end
        endcase
      end
      OP_LW, OP_SW: begin
        dec_o.cls       = (op_i == OP_LW) ? CL_LW : CL_SW;
        dec_o.alu_op    = ALU_ADD;
        dec_o.imm_s     = 1'b1;
        dec_o.rd_rt_s   = 1'b1;
        dec_o.rt_imm_s  = 1'b1;
        dec_o.alu_mem_s = (op_i == OP_LW);
      end
      OP_BEQ, OP_BNE: begin
        dec_o.cls    = CL_BR;
        dec_o.alu_op = ALU_SUB;
        dec_o.imm_s  = 1'b1;
        dec_o.br_ne  = (op_i == OP_BNE);
      end
      OP_J: dec_o.cls = CL_J;
      default: dec_o.cls = CL_NOP;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle control FSM for the CPU datapath: IF -> ID -> EX -> MEM -> WB,
// one phase per clock, with a retired-instruction counter.
// Ports:
//   clk, rst (sync, active low), stall (hold current phase)
//   OP, func        instruction fields from the instruction register
//   ZF              ALU zero flag, used by branches in EX
//   pc_write, pc_src, ir_write, Write_Reg, Mem_Write   enables / PC source
//   rd_rt_s, imm_s, rt_imm_s, alu_mem_s, ALU_OP        datapath selects
//   state           current FSM phase (debug)
//   illegal, retire one-cycle pulses
//   instr_cnt       retired-instruction count (wraps)
// Optional build macro: ILLEGAL_HALT_EN -- an undecodable instruction parks the
// FSM in HALT (state 7) until reset instead of retiring as a NOP.
module multi_cycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [5:0]       OP,
  input  logic [5:0]       func,
  input  logic             ZF,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic             Write_Reg,
  output logic             Mem_Write,
  output logic             rd_rt_s,
  output logic             imm_s,
  output logic             rt_imm_s,
  output logic             alu_mem_s,
  output logic [2:0]       ALU_OP,
  output logic [2:0]       state,
  output logic             illegal,
  output logic             retire,
  output logic [CNT_W-1:0] instr_cnt
);

  state_e           state_q, state_d;
  dec_t             dec;
  dec_t             lat_q, lat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Phase outputs before reset/stall masking
  logic pcw_raw, irw_raw, wr_raw, mw_raw, ill_raw, ret_raw;
  logic run;
  logic br_taken;

  ctrl_decode u_decode (
    .op_i   (OP),
    .func_i (func),
    .dec_o  (dec)
  );

  // A frozen or resetting cycle must not advance or write anything.
  assign run      = rst & ~stall;
  assign br_taken = lat_q.br_ne ? ~ZF : ZF;

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    pcw_raw = 1'b0;
    irw_raw = 1'b0;
    wr_raw  = 1'b0;
    mw_raw  = 1'b0;
    ill_raw = 1'b0;
    ret_raw = 1'b0;
    pc_src  = PC_SEQ;
    case (state_q)
      S_IF: begin
        irw_raw = 1'b1;
        pcw_raw = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        lat_d = dec;
        case (dec.cls)
          CL_J: begin
            pcw_raw = 1'b1;
            pc_src  = PC_JMP;
            ret_raw = 1'b1;
            state_d = S_IF;
          end
          CL_NOP: begin
            ill_raw = 1'b1;
`ifdef ILLEGAL_HALT_EN
            state_d = S_HALT;
`else
            ret_raw = 1'b1;
            state_d = S_IF;
`endif
          end
          default: state_d = S_EX;
        endcase
      end
      S_EX: begin
        case (lat_q.cls)
          CL_LW, CL_SW: state_d = S_MEM;
          CL_BR: begin
            if (br_taken) begin
              pcw_raw = 1'b1;
              pc_src  = PC_BR;
            end
            ret_raw = 1'b1;
            state_d = S_IF;
          end
          CL_R, CL_ALUI: state_d = S_WB;
          default: state_d = S_IF;
        endcase
      end
      S_MEM: begin
        if (lat_q.cls == CL_SW) begin
          mw_raw  = 1'b1;
          ret_raw = 1'b1;
          state_d = S_IF;
        end else begin
          // LW: the extra phase absorbs the synchronous memory read.
          state_d = S_WB;
        end
      end
      S_WB: begin
        wr_raw  = 1'b1;
        ret_raw = 1'b1;
        state_d = S_IF;
      end
`ifdef ILLEGAL_HALT_EN
      S_HALT: state_d = S_HALT;
`endif
      default: state_d = S_IF;
    endcase
    if (!run) begin
      state_d = state_q;
      lat_d   = lat_q;
    end
  end

  assign pc_write  = pcw_raw & run;
  assign ir_write  = irw_raw & run;
  assign Write_Reg = wr_raw  & run;
  assign Mem_Write = mw_raw  & run;
  assign illegal   = ill_raw & run;
  assign retire    = ret_raw & run;

  assign cnt_d = cnt_q + CNT_W'(retire);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IF;
      lat_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ALU_OP    = lat_q.alu_op;
  assign imm_s     = lat_q.imm_s;
  assign rt_imm_s  = lat_q.rt_imm_s;
  assign rd_rt_s   = lat_q.rd_rt_s;
  assign alu_mem_s = lat_q.alu_mem_s;
  assign state     = state_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: vector table, directed corner sequences and
// random instructions checked against a per-class phase model.
module tb_multi_cycle_ctrl;

  localparam int CNT_W = 4;
  localparam int K_ILL = 0, K_R = 1, K_ALUI = 2, K_LW = 3, K_SW = 4, K_BR = 5, K_J = 6;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst, stall, ZF;
  logic [5:0] OP, func;
  logic pc_write, ir_write, Write_Reg, Mem_Write;
  logic rd_rt_s, imm_s, rt_imm_s, alu_mem_s, illegal, retire;
  logic [1:0] pc_src;
  logic [2:0] ALU_OP, state;
  logic [CNT_W-1:0] instr_cnt;

  always #5 clk = ~clk;

  multi_cycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .OP(OP), .func(func), .ZF(ZF),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
    .Write_Reg(Write_Reg), .Mem_Write(Mem_Write), .rd_rt_s(rd_rt_s),
    .imm_s(imm_s), .rt_imm_s(rt_imm_s), .alu_mem_s(alu_mem_s),
    .ALU_OP(ALU_OP), .state(state), .illegal(illegal), .retire(retire),
    .instr_cnt(instr_cnt)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [CNT_W-1:0] exp_cnt;
  logic [10:0] exp_q[$];   // {state, pc_write, pc_src, ir_write, wr, mw, illegal, retire}

  logic [5:0] op_pool [0:11] = '{6'b000000, 6'b000010, 6'b000100, 6'b000101,
                                 6'b001000, 6'b001011, 6'b001100, 6'b001101,
                                 6'b001110, 6'b100011, 6'b101011, 6'b111111};
  logic [5:0] fn_pool [0:7]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                 6'b100110, 6'b100111, 6'b101011, 6'b000100};

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       zf;
    logic [2:0] alu;
    int         lat;
  } vec_t;
  vec_t vt[20];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  function automatic logic [10:0] ph(input int st, input int pcw, input int src,
                                     input int irw, input int wr, input int mw,
                                     input int ill, input int ret);
    return {st[2:0], pcw[0], src[1:0], irw[0], wr[0], mw[0], ill[0], ret[0]};
  endfunction

  function automatic logic [10:0] obs();
    return {state, pc_write, pc_src, ir_write, Write_Reg, Mem_Write, illegal, retire};
  endfunction

  // ---------------- reference model ----------------
  function automatic int model_cls(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000:
        case (fn)
          6'b100000, 6'b100010, 6'b100100, 6'b100101,
          6'b100110, 6'b100111, 6'b101011, 6'b000100: return K_R;
          default: return K_ILL;
        endcase
      6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001011: return K_ALUI;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100, 6'b000101: return K_BR;
      6'b000010: return K_J;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [2:0] model_alu(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'b000000)
      case (fn)
        6'b100000: return 3'b100;
        6'b100010: return 3'b101;
        6'b100100: return 3'b000;
        6'b100101: return 3'b001;
        6'b100110: return 3'b010;
        6'b100111: return 3'b011;
        6'b101011: return 3'b110;
        default:   return 3'b111;
      endcase
    case (op)
      6'b001100: return 3'b000;
      6'b001101: return 3'b001;
      6'b001110: return 3'b010;
      6'b001011: return 3'b110;
      6'b000100, 6'b000101: return 3'b101;
      default:   return 3'b100;
    endcase
  endfunction

  // Expected {ALU_OP, imm_s, rt_imm_s, rd_rt_s, alu_mem_s} and which bits are defined.
  task automatic model_sel(input logic [5:0] op, input logic [5:0] fn, input int k,
                           output logic [6:0] e, output logic [6:0] m);
    logic [2:0] a;
    a = model_alu(op, fn);
    m = 7'b1111111;
    case (k)
      K_R:    begin e = {a, 4'b0000}; m = 7'b1110111; end
      K_ALUI: e = {a, (op == 6'b001000 || op == 6'b001011), 3'b110};
      K_LW:   e = {a, 4'b1111};
      K_SW:   e = {a, 4'b1110};
      K_BR:   begin e = {a, 4'b1000}; m = 7'b1111100; end
      default: begin e = '0; m = '0; end
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk); @(negedge clk); #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_cnt", 32'(instr_cnt), 32'd0);
    exp_cnt = '0;
    rst = 1'b1;
  endtask

  // Drive one instruction from IF through its retire, checking every phase.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic zf,
                           output int lat, output logic [2:0] alu_seen);
    int k, n, taken;
    logic [6:0] se, sm, sg;
    logic [10:0] e, g;
    k = model_cls(op, fn);
    taken = (op == 6'b000100) ? int'(zf) : int'(!zf);
    exp_q.delete();
    exp_q.push_back(ph(0, 1, 0, 1, 0, 0, 0, 0));
    case (k)
      K_J: exp_q.push_back(ph(1, 1, 2, 0, 0, 0, 0, 1));
      K_ILL: begin
`ifdef ILLEGAL_HALT_EN
        exp_q.push_back(ph(1, 0, 0, 0, 0, 0, 1, 0));
        repeat (3) exp_q.push_back(ph(7, 0, 0, 0, 0, 0, 0, 0));
`else
        exp_q.push_back(ph(1, 0, 0, 0, 0, 0, 1, 1));
`endif
      end
      default: begin
        exp_q.push_back(ph(1, 0, 0, 0, 0, 0, 0, 0));
        if (k == K_BR) exp_q.push_back(ph(2, taken, taken, 0, 0, 0, 0, 1));
        else begin
          exp_q.push_back(ph(2, 0, 0, 0, 0, 0, 0, 0));
          if (k == K_LW || k == K_SW)
            exp_q.push_back(ph(3, 0, 0, 0, 0, int'(k == K_SW), 0, int'(k == K_SW)));
          if (k != K_SW) exp_q.push_back(ph(4, 0, 0, 0, 1, 0, 0, 1));
        end
      end
    endcase
    model_sel(op, fn, k, se, sm);
    OP = op; func = fn; ZF = zf;
    lat = 0; alu_seen = '0; n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      #1;
      g = obs();
      n++;
      if (!e[7]) g[6:5] = 2'b00;   // PC source is don't-care unless the PC loads
      chk("trace", 32'(g), 32'(e));
      if (g[0] && lat == 0) lat = n;
      if (n == 3) begin
        alu_seen = ALU_OP;
        sg = {ALU_OP, imm_s, rt_imm_s, rd_rt_s, alu_mem_s};
        if (sm != 7'd0) chk("selects", 32'(sg & sm), 32'(se & sm));
      end
      if (e[0]) exp_cnt = exp_cnt + 1'b1;
      @(posedge clk); @(negedge clk);
    end
    chk("instr_cnt", 32'(instr_cnt), 32'(exp_cnt));
`ifdef ILLEGAL_HALT_EN
    if (k == K_ILL) do_reset();
`endif
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int lat, wr_count;
    logic [2:0] alu;
    logic [5:0] op, fn;

    vt[0]  = '{6'b000000, 6'b100000, 1'b0, 3'b100, 4};
    vt[1]  = '{6'b000000, 6'b100010, 1'b0, 3'b101, 4};
    vt[2]  = '{6'b000000, 6'b100100, 1'b1, 3'b000, 4};
    vt[3]  = '{6'b000000, 6'b100101, 1'b0, 3'b001, 4};
    vt[4]  = '{6'b000000, 6'b100110, 1'b0, 3'b010, 4};
    vt[5]  = '{6'b000000, 6'b100111, 1'b0, 3'b011, 4};
    vt[6]  = '{6'b000000, 6'b101011, 1'b0, 3'b110, 4};
    vt[7]  = '{6'b000000, 6'b000100, 1'b0, 3'b111, 4};
    vt[8]  = '{6'b001000, 6'b010101, 1'b0, 3'b100, 4};
    vt[9]  = '{6'b001100, 6'b000000, 1'b0, 3'b000, 4};
    vt[10] = '{6'b001101, 6'b111111, 1'b0, 3'b001, 4};
    vt[11] = '{6'b001110, 6'b000000, 1'b1, 3'b010, 4};
    vt[12] = '{6'b001011, 6'b000000, 1'b0, 3'b110, 4};
    vt[13] = '{6'b100011, 6'b000000, 1'b0, 3'b100, 5};
    vt[14] = '{6'b101011, 6'b000000, 1'b0, 3'b100, 4};
    vt[15] = '{6'b000100, 6'b000000, 1'b1, 3'b101, 3};
    vt[16] = '{6'b000100, 6'b000000, 1'b0, 3'b101, 3};
    vt[17] = '{6'b000101, 6'b000000, 1'b1, 3'b101, 3};
    vt[18] = '{6'b000101, 6'b000000, 1'b0, 3'b101, 3};
    vt[19] = '{6'b000010, 6'b000000, 1'b0, 3'b000, 2};

    rst = 1'b0; stall = 1'b0; OP = 6'b001000; func = '0; ZF = 1'b0; exp_cnt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_cnt", 32'(instr_cnt), 32'd0);
    chk("reset_enables", 32'({pc_write, ir_write, Write_Reg, Mem_Write, illegal, retire}), 32'd0);
    rst = 1'b1;

    // Vector table
    for (int i = 0; i < 20; i++) begin
      run_instr(vt[i].op, vt[i].fn, vt[i].zf, lat, alu);
      chk("latency", 32'(lat), 32'(vt[i].lat));
      if (vt[i].lat > 2) chk("alu_op", 32'(alu), 32'(vt[i].alu));
    end

    // Illegal instruction
    run_instr(6'b111111, 6'b000000, 1'b0, lat, alu);
`ifdef ILLEGAL_HALT_EN
    chk("illegal_latency", 32'(lat), 32'd0);
`else
    chk("illegal_latency", 32'(lat), 32'd2);
`endif

    // Stall in IF, then three stalled cycles in EX of an addi
    OP = 6'b001000; func = 6'b000011; ZF = 1'b0; stall = 1'b1; wr_count = 0;
    #1;
    chk("stall_if_state", 32'(state), 32'd0);
    chk("stall_if_en", 32'({pc_write, ir_write, Write_Reg, Mem_Write, illegal, retire}), 32'd0);
    @(posedge clk); @(negedge clk); stall = 1'b0; #1;
    chk("post_stall_if", 32'({state, ir_write, pc_write}), 32'({3'd0, 2'b11}));
    @(posedge clk); @(negedge clk); #1;
    chk("stall_id_state", 32'(state), 32'd1);
    @(posedge clk); @(negedge clk); stall = 1'b1;
    repeat (3) begin
      #1;
      chk("stall_ex_state", 32'(state), 32'd2);
      chk("stall_ex_en", 32'({pc_write, ir_write, Write_Reg, Mem_Write, illegal, retire}), 32'd0);
      wr_count += int'(Write_Reg);
      @(posedge clk); @(negedge clk);
    end
    stall = 1'b0; #1;
    chk("ex_after_stall", 32'(state), 32'd2);
    wr_count += int'(Write_Reg);
    @(posedge clk); @(negedge clk); #1;
    chk("wb_after_stall", 32'({state, Write_Reg, retire}), 32'({3'd4, 2'b11}));
    wr_count += int'(Write_Reg);
    @(posedge clk); @(negedge clk);
    exp_cnt = exp_cnt + 1'b1;
    #1;
    chk("stall_wr_count", 32'(wr_count), 32'd1);
    chk("stall_cnt", 32'(instr_cnt), 32'(exp_cnt));
    chk("stall_back_if", 32'(state), 32'd0);

    // Random instructions (counter wraps several times)
    for (int i = 0; i < 150; i++) begin
      op = op_pool[$urandom_range(0, 11)];
      if ($urandom_range(0, 5) == 0) op = 6'($urandom);
      if (op == 6'b000000 && $urandom_range(0, 3) != 0) fn = fn_pool[$urandom_range(0, 7)];
      else fn = 6'($urandom);
      run_instr(op, fn, 1'($urandom_range(0, 1)), lat, alu);
    end

    // Reset during MEM of sw: no write on that edge
    OP = 6'b101011; func = '0;
    if (exp_cnt == '0) begin
      run_instr(6'b000000, 6'b100000, 1'b0, lat, alu);
      OP = 6'b101011;
    end
    repeat (3) begin @(posedge clk); @(negedge clk); end
    #1;
    chk("sw_mem_state", 32'(state), 32'd3);
    chk("sw_mem_write", 32'(Mem_Write), 32'd1);
    rst = 1'b0; #1;
    chk("rst_mem_write", 32'({Mem_Write, retire}), 32'd0);
    @(posedge clk); @(negedge clk); #1;
    chk("rst_mem_state", 32'(state), 32'd0);
    chk("rst_mem_cnt", 32'(instr_cnt), 32'd0);
    exp_cnt = '0;
    rst = 1'b1;
    run_instr(6'b100011, 6'b000000, 1'b0, lat, alu);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
